decr: RTL

- Iterative inverse cipher core; the counterpart of the encryption core.
- Takes a 36-bit ciphertext (four 9-bit words) and produces the 36-bit plaintext.
- Walks the round keys in reverse order. It drives round_no into the shared key_gen and gets back three 9-bit round keys per round.
- Uses three external 9-bit inverse S-box instances, wired through the ports, in the same style as the encryptor's sbox hookup.
- Sits beside encr under the cipher top. Start/busy/done handshake.

---
 rtl/decr_pkg.sv | 34 +++
 rtl/decr_ctrl.sv | 78 +++++++
 rtl/decr.sv | 113 +++++++++++
 3 files changed

// File: rtl/decr_pkg.sv
// Shared constants, FSM encoding and word helpers for the decr inverse cipher core.
package decr_pkg;

    localparam int WORD_W  = 9;
    localparam int STATE_W = 36;
    localparam int KEY_W   = 144;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEY   = 3'd1;
    localparam logic [2:0] ST_SUB   = 3'd2;
    localparam logic [2:0] ST_FINAL = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef logic [WORD_W-1:0] word_t;

    // W0 is the most significant word of the 36-bit block.
    function automatic word_t get_word(input logic [STATE_W-1:0] blk, input logic [1:0] idx);
        word_t w;
        case (idx)
            2'd0:    w = blk[35:27];
            2'd1:    w = blk[26:18];
            2'd2:    w = blk[17:9];
            2'd3:    w = blk[8:0];
            default: w = 9'd0;
        endcase
        return w;
    endfunction

    function automatic logic [STATE_W-1:0] pack_words(input word_t w0, input word_t w1,
                                                      input word_t w2, input word_t w3);
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/decr_ctrl.sv
// Sequencer for decr: FSM, reverse round counter and the registered handshake outputs.
module decr_ctrl
    import decr_pkg::*;
#(
    parameter int NUM_ROUNDS = 32,
    parameter int RND_W      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [2:0]       state,
    output logic [RND_W-1:0] round_no,
    output logic             busy,
    output logic             done
);

    localparam logic [RND_W-1:0] RND_INIT = RND_W'(NUM_ROUNDS);
    localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [RND_W-1:0] rnd_r;
    logic [RND_W-1:0] rnd_nxt_s;
    logic [RND_W-1:0] round_no_r;
    logic             busy_r;
    logic             done_r;

    // Next-state and counter logic; the counter stops at 1 so it never wraps.
    always_comb begin
        state_nxt_s = state_r;
        rnd_nxt_s   = rnd_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_KEY;
                    rnd_nxt_s   = RND_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_KEY:   state_nxt_s = ST_SUB;
            ST_SUB: begin
                if (rnd_r == RND_ONE) begin
                    state_nxt_s = ST_FINAL;
                end else begin
                    state_nxt_s = ST_KEY;
                    rnd_nxt_s   = rnd_r - RND_ONE;
                end
            end
            ST_FINAL: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State registers; outputs are derived from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rnd_r      <= {RND_W{1'b0}};
            round_no_r <= {RND_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rnd_r      <= rnd_nxt_s;
            round_no_r <= (state_nxt_s == ST_KEY) ? rnd_nxt_s : {RND_W{1'b0}};
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    assign state    = state_r;
    assign round_no = round_no_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: rtl/decr.sv
// Iterative inverse cipher core: reverse-keyed rounds through external inverse S-boxes
// and key_gen, followed by a whitening step.
module decr
    import decr_pkg::*;
#(
    parameter int NUM_ROUNDS = 32,
    parameter int RND_W      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [35:0]      ct_in,
    output logic             busy,
    output logic             done,
    output logic [35:0]      pt_out,
    output logic [RND_W-1:0] round_no,
    input  logic [8:0]       key1,
    input  logic [8:0]       key2,
    input  logic [8:0]       key3,
    output logic [8:0]       isbox_ip_1,
    output logic [8:0]       isbox_ip_2,
    output logic [8:0]       isbox_ip_3,
    input  logic [8:0]       isbox_op_1,
    input  logic [8:0]       isbox_op_2,
    input  logic [8:0]       isbox_op_3
);

    logic [2:0]         state_s;
    word_t              w0_r, w1_r, w2_r, w3_r;
    word_t              kx1_s, kx2_s, kx3_s;
    logic [STATE_W-1:0] white_s;
    logic [STATE_W-1:0] pt_out_r;
    word_t              ip1_r, ip2_r, ip3_r;

    decr_ctrl #(
        .NUM_ROUNDS(NUM_ROUNDS),
        .RND_W     (RND_W)
    ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .state   (state_s),
        .round_no(round_no),
        .busy    (busy),
        .done    (done)
    );

    // Key mixing for the round and final whitening (W0 and W1 both take key1).
    always_comb begin
        kx1_s   = w1_r ^ key1;
        kx2_s   = w2_r ^ key2;
        kx3_s   = w3_r ^ key3;
        white_s = pack_words(w0_r ^ key1, w1_r ^ key1, w2_r ^ key2, w3_r ^ key3);
    end

    // Working state and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0_r     <= 9'd0;
            w1_r     <= 9'd0;
            w2_r     <= 9'd0;
            w3_r     <= 9'd0;
            pt_out_r <= 36'd0;
        end else begin
            case (state_s)
                ST_IDLE: begin
                    if (start) begin
                        w0_r <= get_word(ct_in, 2'd0);
                        w1_r <= get_word(ct_in, 2'd1);
                        w2_r <= get_word(ct_in, 2'd2);
                        w3_r <= get_word(ct_in, 2'd3);
                    end
                end
                ST_KEY: begin
                    w1_r <= kx1_s;
                    w2_r <= kx2_s;
                    w3_r <= kx3_s;
                end
                ST_SUB: begin
                    w0_r <= isbox_op_1;
                    w1_r <= isbox_op_2;
                    w2_r <= isbox_op_3;
                    w3_r <= w0_r ^ isbox_op_1;
                end
                ST_FINAL: pt_out_r <= white_s;
                default:  pt_out_r <= pt_out_r;
            endcase
        end
    end

    // S-box inputs are loaded on the KEY->SUB edge with the freshly keyed words, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip1_r <= 9'd0;
            ip2_r <= 9'd0;
            ip3_r <= 9'd0;
        end else if (state_s == ST_KEY) begin
            ip1_r <= kx1_s;
            ip2_r <= kx2_s;
            ip3_r <= kx3_s;
        end else begin
            ip1_r <= 9'd0;
            ip2_r <= 9'd0;
            ip3_r <= 9'd0;
        end
    end

    assign pt_out     = pt_out_r;
    assign isbox_ip_1 = ip1_r;
    assign isbox_ip_2 = ip2_r;
    assign isbox_ip_3 = ip3_r;

endmodule
